// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring divider with start/ready handshake (optional SIGNED_DIV_EN)
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             ready,
    output logic             busy,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_count;

    logic             w_start;
    logic             w_last;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_dvd_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef SIGNED_DIV_EN
    logic r_neg_q;
    logic r_neg_r;
    logic w_a_neg;
    logic w_b_neg;

    // Signed operands are reduced to magnitudes at start; signs are re-applied on completion
    always_comb begin
        w_a_neg = A[WIDTH-1];
        w_b_neg = B[WIDTH-1];
        w_a_mag = w_a_neg ? (~A + 1'b1) : A;
        w_b_mag = w_b_neg ? (~B + 1'b1) : B;
        w_q_fix = r_neg_q ? (~w_dvd_next + 1'b1) : w_dvd_next;
        w_r_fix = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    end
`else
    // Unsigned build: operands and results pass straight through
    always_comb begin
        w_a_mag = A;
        w_b_mag = B;
        w_q_fix = w_dvd_next;
        w_r_fix = w_rem_next;
    end
`endif

    // One restoring step: shift in the next dividend bit, trial subtract, keep or restore.
    // The trial is WIDTH+1 bits so its MSB is the borrow.
    always_comb begin
        w_shift    = {r_rem, r_dvd[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_dvs};
        w_qbit     = ~w_trial[WIDTH];
        w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_dvd_next = {r_dvd[WIDTH-2:0], w_qbit};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; en is only honoured when not iterating
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_last   = 1'b0;
        w_b_zero = (B == '0);
        case (r_state)
            S_IDLE, S_DONE: begin
                if (en) begin
                    w_start = 1'b1;
                    w_next  = w_b_zero ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (r_count == LAST_COUNT) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; results only update on completion or divide-by-zero start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            Quotient    <= '0;
            Remainder   <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
`endif
        end else if (w_start) begin
            if (w_b_zero) begin
                Quotient    <= '1;
                Remainder   <= A;
                div_by_zero <= 1'b1;
                ready       <= 1'b1;
                busy        <= 1'b0;
            end else begin
                r_dvd   <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= '0;
                r_count <= '0;
                ready   <= 1'b0;
                busy    <= 1'b1;
`ifdef SIGNED_DIV_EN
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
`endif
            end
        end else if (r_state == S_ITER) begin
            r_dvd   <= w_dvd_next;
            r_rem   <= w_rem_next;
            r_count <= r_count + 1'b1;
            if (w_last) begin
                Quotient    <= w_q_fix;
                Remainder   <= w_r_fix;
                ready       <= 1'b1;
                busy        <= 1'b0;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider
module tb_seq_divider;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Quotient;
    logic [7:0] Remainder;
    logic       ready;
    logic       busy;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
        int         start;
    } exp_t;

    exp_t sb[$];
    exp_t last_res;
    bit   have_last;
    int   cyc;
    int   errors;
    int   checks;
    logic prev_ready;

    seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .A          (A),
        .B          (B),
        .Quotient   (Quotient),
        .Remainder  (Remainder),
        .ready      (ready),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each freshly presented result with the oldest expectation,
    // and confirm a presented result stays stable while ready is held.
    always @(negedge clk) begin
        if (ready === 1'b1 && prev_ready !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                last_res = sb.pop_front();
                have_last = 1'b1;
                check("quotient", {24'd0, Quotient}, {24'd0, last_res.q});
                check("remainder", {24'd0, Remainder}, {24'd0, last_res.r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, last_res.dbz});
                check("busy_at_done", {31'd0, busy}, 32'd0);
                check("latency", cyc - last_res.start + 1, last_res.lat);
            end
        end else if (ready === 1'b1 && have_last) begin
            check("hold_quotient", {24'd0, Quotient}, {24'd0, last_res.q});
            check("hold_remainder", {24'd0, Remainder}, {24'd0, last_res.r});
        end
        prev_ready = ready;
    end

    // Drive one start; optionally record its expected result
    task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input bit push);
        @(negedge clk);
        A  = a;
        B  = b;
        en = 1'b1;
        if (push) sb.push_back('{eq, er, (b == 8'd0), (b == 8'd0) ? 1 : 9, cyc + 1});
        @(negedge clk);
        en = 1'b0;
        if (push) begin
            check("busy_after_start", {31'd0, busy}, {31'd0, (b != 8'd0)});
            check("ready_after_start", {31'd0, ready}, {31'd0, (b == 8'd0)});
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_q"}, {24'd0, Quotient}, 32'd0);
        check({tag, "_r"}, {24'd0, Remainder}, 32'd0);
        check({tag, "_flags"}, {29'd0, ready, busy, div_by_zero}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        have_last = 1'b0;
        prev_ready = 1'b0;
        en = 1'b0;
        A = 8'd0;
        B = 8'd0;
        reset = 1'b1;
        #12;
        check_outputs_zero("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // basic divisions
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b1);
        wait_ready();
        repeat (3) @(negedge clk);
        start_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b1);
        wait_ready();
        start_op(8'd3, 8'd200, 8'd0, 8'd3, 1'b1);
        wait_ready();

        // divide by zero from IDLE
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start_op(8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        wait_ready();

        // en while busy is ignored, then restart from DONE
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b1);
        start_op(8'd9, 8'd3, 8'd0, 8'd0, 1'b0);
        wait_ready();
        start_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b1);
        wait_ready();

        // asynchronous reset mid-operation discards the operation
        start_op(8'd100, 8'd7, 8'd0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_outputs_zero("async_reset");
        @(negedge clk);
        reset = 1'b0;
`ifdef SIGNED_DIV_EN
        start_op(8'd200, 8'd13, 8'hFC, 8'hFC, 1'b1);
        wait_ready();
        start_op(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b1);
        wait_ready();
        start_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b1);
        wait_ready();
        start_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b1);
        wait_ready();
`else
        start_op(8'd200, 8'd13, 8'd15, 8'd5, 1'b1);
        wait_ready();
        start_op(8'd200, 8'd200, 8'd1, 8'd0, 1'b1);
        wait_ready();
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
